// File: rtl/cond_logic_pkg.sv
// Shared controller definitions: ARM condition-code encodings and NZCV flag bit positions.
package cond_logic_pkg;

  localparam int unsigned COND_W = 4;
  localparam int unsigned FLAGS_W = 4;

  typedef enum logic [COND_W-1:0] {
    COND_EQ = 4'b0000,
    COND_NE = 4'b0001,
    COND_CS = 4'b0010,
    COND_CC = 4'b0011,
    COND_MI = 4'b0100,
    COND_PL = 4'b0101,
    COND_VS = 4'b0110,
    COND_VC = 4'b0111,
    COND_HI = 4'b1000,
    COND_LS = 4'b1001,
    COND_GE = 4'b1010,
    COND_LT = 4'b1011,
    COND_GT = 4'b1100,
    COND_LE = 4'b1101,
    COND_AL = 4'b1110,
    COND_NV = 4'b1111
  } cond_e;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

endpackage

// File: rtl/cond_logic_if.sv
// Control-strobe bundle between the main controller FSM and the conditional-execution stage.
interface cond_logic_if;
  import cond_logic_pkg::*;

  logic [COND_W-1:0]  Cond;
  logic [FLAGS_W-1:0] ALUFlags;
  logic [1:0]         FlagW;
  logic               PCS;
  logic               NextPC;
  logic               RegW;
  logic               MemW;
  logic               PCWrite;
  logic               RegWrite;
  logic               MemWrite;
  logic [FLAGS_W-1:0] Flags;

  modport master (
    output Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    input  PCWrite, RegWrite, MemWrite, Flags
  );

  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, NextPC, RegW, MemW,
    output PCWrite, RegWrite, MemWrite, Flags
  );

endinterface

// File: rtl/cond_logic_cond_check.sv
// Combinational evaluator of an ARM condition field against the NZCV flags.
module cond_check
  import cond_logic_pkg::*;
(
  input  logic [COND_W-1:0]  cond_i,
  input  logic [FLAGS_W-1:0] flags_i,
  output logic               cond_ex_o
);

  logic n, z, c, v, ge;

  always_comb begin
    n  = flags_i[FLAG_N];
    z  = flags_i[FLAG_Z];
    c  = flags_i[FLAG_C];
    v  = flags_i[FLAG_V];
    ge = (n == v);
    cond_ex_o = 1'b0;
    case (cond_e'(cond_i))
      COND_EQ: cond_ex_o = z;
      COND_NE: cond_ex_o = ~z;
      COND_CS: cond_ex_o = c;
      COND_CC: cond_ex_o = ~c;
      COND_MI: cond_ex_o = n;
      COND_PL: cond_ex_o = ~n;
      COND_VS: cond_ex_o = v;
      COND_VC: cond_ex_o = ~v;
      COND_HI: cond_ex_o = c & ~z;
      COND_LS: cond_ex_o = ~(c & ~z);
      COND_GE: cond_ex_o = ge;
      COND_LT: cond_ex_o = ~ge;
      COND_GT: cond_ex_o = ~z & ge;
      COND_LE: cond_ex_o = ~(~z & ge);
      COND_AL: cond_ex_o = 1'b1;
      default: cond_ex_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field and gates the
// FSM write strobes with the condition result from the previous cycle.
module cond_logic
  import cond_logic_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  cond_logic_if.slave  bus
);

  logic [FLAGS_W-1:0] flags_q, flags_d;
  logic               cond_ex_q;
  logic               cond_ex;
  logic [1:0]         flag_write;

  cond_check u_cond_check (
    .cond_i    (bus.Cond),
    .flags_i   (flags_q),
    .cond_ex_o (cond_ex)
  );

  // The N,Z and C,V groups load independently, both gated by this cycle's condition.
  always_comb begin
    flag_write = bus.FlagW & {2{cond_ex}};
    flags_d    = flags_q;
    if (flag_write[1]) begin
      flags_d[FLAG_N] = bus.ALUFlags[FLAG_N];
      flags_d[FLAG_Z] = bus.ALUFlags[FLAG_Z];
    end
    if (flag_write[0]) begin
      flags_d[FLAG_C] = bus.ALUFlags[FLAG_C];
      flags_d[FLAG_V] = bus.ALUFlags[FLAG_V];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q   <= '0;
      cond_ex_q <= 1'b0;
    end else begin
      flags_q   <= flags_d;
      cond_ex_q <= cond_ex;
    end
  end

  // Writeback strobes arrive one state after the condition was evaluated.
  assign bus.PCWrite  = (bus.PCS & cond_ex_q) | bus.NextPC;
  assign bus.RegWrite = bus.RegW & cond_ex_q;
  assign bus.MemWrite = bus.MemW & cond_ex_q;
  assign bus.Flags    = flags_q;

endmodule

// File: doc/cond_logic.md
# cond_logic

Conditional-execution stage of the multicycle ARM controller, directly downstream of the main control FSM. It holds the architectural NZCV flags and evaluates the instruction's condition field against them. Using a one-cycle-delayed condition result, it gates the FSM's raw write strobes (RegW, MemW, PCS) into the final datapath enables (RegWrite, MemWrite, PCWrite). NextPC bypasses condition gating so that instruction fetch always advances the PC.

## Interface
Parameters: none.
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  reset, asynchronous, active-high; clock clk
- Cond  in  4  instruction condition field, Instr[31:28]
- ALUFlags  in  4  ALU result flags {N,Z,C,V}
- FlagW  in  2  flag-write request from decoder; [1] = N,Z group, [0] = C,V group
- PCS  in  1  PC-source request (branch, or a write to R15) from FSM/decoder
- NextPC  in  1  unconditional PC advance (fetch state)
- RegW  in  1  raw register-write strobe from FSM
- MemW  in  1  raw memory-write strobe from FSM
- PCWrite  out  1  final PC register enable
- RegWrite  out  1  final register-file write enable
- MemWrite  out  1  final data-memory write enable
- Flags  out  4  current architectural flags {N,Z,C,V}; debug/visibility

## Operation
- Flag register: four flops, Flags = {N,Z,C,V}, each reset to 0.
- CondEx is combinational, computed from Cond and the current registered Flags:
  - EQ 0000 = Z; NE 0001 = ~Z
  - CS 0010 = C; CC 0011 = ~C
  - MI 0100 = N; PL 0101 = ~N
  - VS 0110 = V; VC 0111 = ~V
  - HI 1000 = C&~Z; LS 1001 = ~(C&~Z)
  - GE 1010 = (N==V); LT 1011 = (N!=V)
  - GT 1100 = ~Z&(N==V); LE 1101 = ~(~Z&(N==V))
  - AL 1110 = 1; 1111 = 0 (treated as never-execute)
- FlagWrite[1:0] = FlagW & {2{CondEx}}.
  - FlagWrite[1] loads Flags[3:2] from ALUFlags[3:2].
  - FlagWrite[0] loads Flags[1:0] from ALUFlags[1:0].
  - The two groups are independent.
- CondExDelayed: a flop that captures CondEx on every clock edge (no enable); reset value 0.
- Output gating (combinational from registered state):
  - PCWrite = (PCS & CondExDelayed) | NextPC
  - RegWrite = RegW & CondExDelayed
  - MemWrite = MemW & CondExDelayed
- The delay is deliberate: the FSM evaluates the condition in EXECUTE/MEMADR and issues writeback strobes one state later (ALUWB, MEMWR, MEMWB, BRANCH completion). The stored result must therefore be the one from the preceding cycle.

## Timing
- Reset (asynchronous): Flags = 0000 and CondExDelayed = 0 immediately.
  - While reset is held: RegWrite = MemWrite = 0 and PCWrite = NextPC.
- Flag update: visible on Flags in the cycle after FlagWrite is asserted. CondEx in the write cycle uses the pre-update flags, so an instruction never conditions on its own result.
- Simultaneous flag write and condition check in the same cycle: the check uses the old flags; the write is gated by that same CondEx.
- Latency of CondEx to the write enables: exactly 1 cycle.
- NextPC = 1 forces PCWrite = 1 regardless of CondExDelayed or PCS.
- Reset deasserted mid-instruction: CondExDelayed = 0, so no spurious register or memory write occurs on the first post-reset cycle.
- Outputs carry no additional registering: combinational paths are PCS/RegW/MemW/NextPC to the outputs, and Flags/Cond to FlagWrite.

## Structure
- Shared controller package holds:
  - the 4-bit condition-code constants (COND_EQ … COND_NV)
  - flag bit indices (FLAG_N = 3, FLAG_Z = 2, FLAG_C = 1, FLAG_V = 0)
- One sub-module, cond_check: a purely combinational Cond × Flags → CondEx evaluator.
- cond_logic instantiates cond_check and holds the flag flops, the CondExDelayed flop and the output gating.

## Test plan
- Reset: assert reset with NextPC = 1, RegW = MemW = 1 → Flags = 0000, PCWrite = 1, RegWrite = 0, MemWrite = 0.
- EQ path:
  - Setup: ALUFlags = 0100, FlagW = 11, Cond = 1110 for one cycle → Flags = 0100.
  - Check: Cond = 0000 → CondEx = 1; RegW = 1 on the next cycle → RegWrite = 1.
  - Repeat with Cond = 0001 → RegWrite = 0.
- Gated flag write: Flags = 0000, Cond = 0000 (fails), FlagW = 11, ALUFlags = 1111 → Flags stays 0000.
- Group independence: FlagW = 01, ALUFlags = 1111, Cond = AL, from Flags = 0000 → Flags = 0011; N and Z are unchanged.
- Signed conditions with Flags = 1000 (N = 1, V = 0): GE → 0, LT → 1, GT → 0, LE → 1. Then Cond = 1111 → CondEx = 0, and MemWrite = 0 even with MemW = 1.
- Branch: Cond fails, PCS = 1 next cycle → PCWrite = 0; NextPC = 1 in the same cycle → PCWrite = 1.
